// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V instruction fetch slice.
package riscv_pkg;

  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] PC_STEP = 32'd4;
  localparam logic [ILEN-1:0] NOP_INS = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    FETCH_HOLD = 3'd2,
    FULL       = 3'd3,
    DISCARD    = 3'd4
  } fetch_state_t;

  function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] addr);
    return {addr[ILEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_skid.sv
// One-entry instruction/pc buffer that catches a word arriving while the
// decoder is stalled.
module riscv_fetch_skid import riscv_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [ILEN-1:0] data_in,
  input  logic [ILEN-1:0] pc_in,
  output logic [ILEN-1:0] data,
  output logic [ILEN-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      pc   <= '0;
    end else if (load) begin
      data <= data_in;
      pc   <= pc_in;
    end else if (clear) begin
      data <= '0;
      pc   <= '0;
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, valid/ready output to
// the decoder, branch redirects taken only in consume cycles.
module riscv_fetch_unit import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = riscv_pkg::NOP_INS
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget
);

  fetch_state_t state;
  logic         consume;
  logic         redirect;
  logic         ack;
  logic         skid_load;
  logic         skid_clear;
  logic [31:0]  next_addr;
  logic [31:0]  target;
  logic [31:0]  target_q;
  logic [31:0]  skid_data;
  logic [31:0]  skid_pc;

  assign consume    = ins_valid & ins_ready;
  assign redirect   = consume & PCSrc;
  assign ack        = imem_req & imem_ack;
  assign next_addr  = imem_addr + PC_STEP;
  assign target     = align_pc(PCTarget);
  assign skid_load  = (state == FETCH_HOLD) & ack & ~consume;
  assign skid_clear = (state == FULL) & consume;

  riscv_fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .data_in (imem_rdata),
    .pc_in   (imem_addr),
    .data    (skid_data),
    .pc      (skid_pc)
  );

  // Whenever ins_valid drops, Ins is forced back to NOP so the decoder sees a harmless opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= align_pc(RESET_PC);
      Ins       <= NOP_INS;
      ins_pc    <= RESET_PC;
      ins_valid <= 1'b0;
      target_q  <= align_pc(RESET_PC);
    end else begin
      unique case (state)
        IDLE: begin
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        FETCH: begin
          if (ack) begin
            Ins       <= imem_rdata;
            ins_pc    <= imem_addr;
            ins_valid <= 1'b1;
            imem_addr <= next_addr;
            state     <= FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (redirect) begin
            ins_valid <= 1'b0;
            Ins       <= NOP_INS;
            if (ack) begin
              imem_addr <= target;
              state     <= FETCH;
            end else begin
              // The pending request must still complete; its data gets dropped.
              target_q <= target;
              state    <= DISCARD;
            end
          end else if (consume) begin
            if (ack) begin
              Ins       <= imem_rdata;
              ins_pc    <= imem_addr;
              imem_addr <= next_addr;
            end else begin
              ins_valid <= 1'b0;
              Ins       <= NOP_INS;
              state     <= FETCH;
            end
          end else if (ack) begin
            imem_req  <= 1'b0;
            imem_addr <= next_addr;
            state     <= FULL;
          end
        end
        FULL: begin
          if (redirect) begin
            ins_valid <= 1'b0;
            Ins       <= NOP_INS;
            imem_req  <= 1'b1;
            imem_addr <= target;
            state     <= FETCH;
          end else if (consume) begin
            Ins      <= skid_data;
            ins_pc   <= skid_pc;
            imem_req <= 1'b1;
            state    <= FETCH_HOLD;
          end
        end
        DISCARD: begin
          if (ack) begin
            imem_addr <= target_q;
            state     <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: directed scenarios plus a random
// run checked against an instruction-stream model of a word-addressed memory.
module tb_riscv_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        PCSrc;
  logic [31:0] PCTarget;

  int checks = 0;
  int errors = 0;
  int mem_wait = 0;
  int mem_cnt = 0;
  int consumed = 0;
  bit rand_mem = 0;

  logic [31:0] exp_pc;
  logic        prev_req, prev_ack, prev_valid, prev_ready;
  logic [31:0] prev_addr, prev_ins, prev_pc;

  riscv_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Ins        (Ins),
    .ins_pc     (ins_pc),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory contents: an odd multiplier makes every aligned address hold a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req"},   {31'b0, imem_req},  32'd0);
    checkOutput({tag, "_addr"},  imem_addr,          32'd0);
    checkOutput({tag, "_ins"},   Ins,                NOP);
    checkOutput({tag, "_pc"},    ins_pc,             32'd0);
    checkOutput({tag, "_valid"}, {31'b0, ins_valid}, 32'd0);
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    ins_ready  = 1'b0;
    PCSrc      = 1'b0;
    PCTarget   = 32'd0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    rst_n      = 1'b1;
    exp_pc     = 32'd0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    mem_cnt    = 0;
    mem_wait   = 0;
    rand_mem   = 0;
  endtask

  // Called at a falling edge: checks protocol rules, drives one cycle of inputs
  // (memory model included), tracks the expected instruction stream, then
  // advances to the next falling edge.
  task automatic applyStimulus(input bit ready, input bit src, input logic [31:0] tgt);
    if (prev_req && !prev_ack) begin
      checkOutput("req_held", {31'b0, imem_req}, 32'd1);
      checkOutput("addr_stable", imem_addr, prev_addr);
    end
    if (prev_valid && !prev_ready) begin
      checkOutput("valid_stable", {31'b0, ins_valid}, 32'd1);
      checkOutput("ins_stable", Ins, prev_ins);
      checkOutput("pc_stable", ins_pc, prev_pc);
    end
    if (!ins_valid) checkOutput("nop_when_invalid", Ins, NOP);

    ins_ready = ready;
    PCSrc     = src;
    PCTarget  = tgt;
    if (imem_req) begin
      if (mem_cnt >= mem_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_cnt    = 0;
        if (rand_mem) mem_wait = $urandom_range(0, 3);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        mem_cnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      mem_cnt    = 0;
    end

    if (ins_valid && ready) begin
      checkOutput("stream_pc", ins_pc, exp_pc);
      checkOutput("stream_word", Ins, mem_word(exp_pc));
      consumed++;
      exp_pc = src ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
    end

    prev_req   = imem_req;
    prev_ack   = imem_ack;
    prev_addr  = imem_addr;
    prev_valid = ins_valid;
    prev_ready = ready;
    prev_ins   = Ins;
    prev_pc    = ins_pc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Back-to-back fetch at full throughput.
    doReset();
    checkOutput("t1_idle_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      checkOutput("t1_req", {31'b0, imem_req}, 32'd1);
      checkOutput("t1_addr", imem_addr, 32'(4 * c));
      checkOutput("t1_valid", {31'b0, ins_valid}, (c >= 1) ? 32'd1 : 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
    end

    // Three wait states per access.
    doReset();
    mem_wait = 3;
    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("t2_req_wait", {31'b0, imem_req}, 32'd1);
      checkOutput("t2_addr_wait", imem_addr, 32'd0);
      checkOutput("t2_valid_wait", {31'b0, ins_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
    end
    checkOutput("t2_valid", {31'b0, ins_valid}, 32'd1);
    checkOutput("t2_pc", ins_pc, 32'd0);
    checkOutput("t2_next_addr", imem_addr, 32'd4);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t2_gap_valid", {31'b0, ins_valid}, 32'd0);
    checkOutput("t2_gap_ins", Ins, NOP);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, 32'd0);

    // Decoder stall fills the skid buffer.
    doReset();
    for (int k = 0; k < 5; k++) begin
      if (k >= 3) begin
        checkOutput("t3_req_dropped", {31'b0, imem_req}, 32'd0);
        checkOutput("t3_held_pc", ins_pc, 32'd0);
        checkOutput("t3_held_ins", Ins, mem_word(32'd0));
      end
      applyStimulus(1'b0, 1'b0, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t3_skid_pc", ins_pc, 32'd4);
    checkOutput("t3_skid_ins", Ins, mem_word(32'd4));
    checkOutput("t3_resume_req", {31'b0, imem_req}, 32'd1);
    checkOutput("t3_resume_addr", imem_addr, 32'd8);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 32'd0);

    // Redirect taken while the skid buffer is full.
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("t4_full_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    checkOutput("t4_redir_req", {31'b0, imem_req}, 32'd1);
    checkOutput("t4_redir_addr", imem_addr, 32'h0000_0100);
    checkOutput("t4_redir_valid", {31'b0, ins_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t4_target_pc", ins_pc, 32'h0000_0100);
    checkOutput("t4_target_ins", Ins, mem_word(32'h0000_0100));
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'd0);

    // Redirect while the request to 0x8 is still waiting: its data must be dropped.
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t5_pending_addr", imem_addr, 32'd8);
    mem_wait = 2;
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    checkOutput("t5_discard_addr", imem_addr, 32'd8);
    checkOutput("t5_discard_valid", {31'b0, ins_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t5_new_addr", imem_addr, 32'h0000_0100);
    checkOutput("t5_new_valid", {31'b0, ins_valid}, 32'd0);
    mem_wait = 0;
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t5_target_pc", ins_pc, 32'h0000_0100);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'd0);

    // Address wrap at the top of memory, then asynchronous reset mid-request.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF);
    checkOutput("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t6_wrap_addr", imem_addr, 32'd0);
    checkOutput("t6_top_pc", ins_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t6_wrap_pc", ins_pc, 32'd0);
    checkOutput("t6_req_before_reset", {31'b0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 checkResetValues("async_reset");

    // Random traffic: wait states, stalls, and redirects to arbitrary targets.
    doReset();
    rand_mem = 1;
    mem_wait = $urandom_range(0, 3);
    consumed = 0;
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), $urandom);
    end
    checkOutput("random_progress", {31'b0, (consumed > 300)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
